// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: redirect input from npc, the instruction-memory request/response
// channel, and the decode-facing instruction output.
interface fetch_unit_if;
   logic [29:0] npc_in;
   logic        redirect;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [29:0] if_pc;
   logic        id_ready;

   modport master (
      input  npc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      output imem_req, imem_addr, if_valid, if_instr, if_pc
   );

   modport slave (
      output npc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, a 2-entry {pc, instr} buffer toward
// decode, and a REQ/WAIT/FLUSH FSM that drops responses orphaned by a redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_e;

   localparam logic [29:0] RESET_WADDR = RESET_PC[31:2];

   state_e      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [29:0] req_pc_q, req_pc_d;
   logic [1:0]  count_q, count_d;
   logic [29:0] fifo_pc_q    [2];
   logic [31:0] fifo_instr_q [2];

   logic imem_req, accept, push, pop, if_valid, wr_sel;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_REQ;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      case (state_q)
         S_REQ:   if (accept) state_d = S_WAIT;
         S_WAIT: begin
            if (bus.imem_rvalid)   state_d = S_REQ;
            else if (bus.redirect) state_d = S_FLUSH;
         end
         S_FLUSH: if (bus.imem_rvalid) state_d = S_REQ;
         default: state_d = S_REQ;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      imem_req = 1'b0;
      push     = 1'b0;
      case (state_q)
         S_REQ:   imem_req = !rst && (count_q < 2'd2) && !bus.redirect;
         S_WAIT:  push     = !rst && bus.imem_rvalid && !bus.redirect;
         default: ;
      endcase
   end

   assign accept   = imem_req && bus.imem_gnt;
   assign if_valid = !rst && (count_q != 2'd0) && !bus.redirect;
   assign pop      = if_valid && bus.id_ready;

   // A push lands behind the head unless the head leaves in the same cycle.
   assign wr_sel = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

   // ---------------- PC / count next state ----------------
   always_comb begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      count_d  = count_q;
      if (bus.redirect) begin
         pc_d    = bus.npc_in;
         count_d = 2'd0;
      end else begin
         if (accept) begin
            pc_d     = pc_q + 30'd1;
            req_pc_d = pc_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_WADDR;
         req_pc_q <= '0;
         count_q  <= 2'd0;
      end else begin
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         count_q  <= count_d;
      end
   end

   // NOTE: buffer storage is deliberately not reset; count_q alone says which entries are live.
   always_ff @(posedge clk) begin
      if (pop) begin
         fifo_pc_q[0]    <= fifo_pc_q[1];
         fifo_instr_q[0] <= fifo_instr_q[1];
      end
      // NOTE: with non-blocking assignments the later write wins, so a push into slot 0
      // correctly overrides the shift from slot 1 on a simultaneous push and pop.
      if (push) begin
         fifo_pc_q[wr_sel]    <= req_pc_q;
         fifo_instr_q[wr_sel] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req  = imem_req;
   assign bus.imem_addr = pc_q;
   assign bus.if_valid  = if_valid;
   assign bus.if_pc     = rst ? 30'd0 : fifo_pc_q[0];
   assign bus.if_instr  = rst ? 32'd0 : fifo_instr_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each cycle drives the memory/decode/redirect inputs by hand
// and compares outputs against hand-computed values.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Apply one cycle's inputs and let combinational outputs settle.
   task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [29:0] npc, input logic rdy);
      bus.imem_gnt    = gnt;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rd;
      bus.redirect    = redir;
      bus.npc_in      = npc;
      bus.id_ready    = rdy;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // ---- reset: outputs held idle, redirect/rvalid overridden ----
      drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 30'h0000_1111, 1'b1);
      tick();
      tick();
      check("rst_req",   32'(bus.imem_req), 32'd0);
      check("rst_valid", 32'(bus.if_valid), 32'd0);
      check("rst_instr", bus.if_instr,      32'd0);
      check("rst_pc",    32'(bus.if_pc),    32'd0);
      check("rst_addr",  32'(bus.imem_addr), 32'h0C00);
      rst = 1'b0;

      // ---- sequential fetch, gnt=1, response one cycle later, id_ready=1 ----
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("seq_req0",  32'(bus.imem_req),  32'd1);
      check("seq_addr0", 32'(bus.imem_addr), 32'h0C00);
      tick();
      drive(1'b1, 1'b1, 32'hA000_0000, 1'b0, 30'd0, 1'b1);
      check("seq_wait_req", 32'(bus.imem_req), 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("seq_v0",    32'(bus.if_valid),  32'd1);
      check("seq_pc0",   32'(bus.if_pc),     32'h0C00);
      check("seq_i0",    bus.if_instr,       32'hA000_0000);
      check("seq_addr1", 32'(bus.imem_addr), 32'h0C01);
      tick();
      drive(1'b1, 1'b1, 32'hA000_0001, 1'b0, 30'd0, 1'b1);
      check("seq_empty", 32'(bus.if_valid), 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("seq_pc1",   32'(bus.if_pc),     32'h0C01);
      check("seq_i1",    bus.if_instr,       32'hA000_0001);
      check("seq_addr2", 32'(bus.imem_addr), 32'h0C02);
      tick();
      drive(1'b1, 1'b1, 32'hA000_0002, 1'b0, 30'd0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("seq_pc2", 32'(bus.if_pc), 32'h0C02);
      check("seq_i2",  bus.if_instr,   32'hA000_0002);

      // ---- backpressure: buffer fills to 2, request stops, head holds ----
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'hB000_0000, 1'b0, 30'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      check("bp_req1", 32'(bus.imem_req), 32'd1);
      tick();
      drive(1'b1, 1'b1, 32'hB000_0001, 1'b0, 30'd0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
         check("bp_full_req", 32'(bus.imem_req), 32'd0);
         check("bp_hold_pc",  32'(bus.if_pc),    32'h0C00);
         check("bp_hold_i",   bus.if_instr,      32'hB000_0000);
         tick();
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("bp_pop_pc", 32'(bus.if_pc), 32'h0C00);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      check("bp_next_pc", 32'(bus.if_pc),     32'h0C01);
      check("bp_next_i",  bus.if_instr,       32'hB000_0001);
      check("bp_resume",  32'(bus.imem_req),  32'd1);
      check("bp_addr",    32'(bus.imem_addr), 32'h0C02);

      // ---- redirect in WAIT, late response is flushed ----
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 30'h1234, 1'b1);
      check("fl_req_redir", 32'(bus.imem_req), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("fl_req",  32'(bus.imem_req),  32'd0);
      check("fl_addr", 32'(bus.imem_addr), 32'h1234);
      tick();
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 30'd0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("fl_empty",    32'(bus.if_valid),  32'd0);
      check("fl_next_req", 32'(bus.imem_req),  32'd1);
      check("fl_next_adr", 32'(bus.imem_addr), 32'h1234);

      // ---- redirect coincident with rvalid: response dropped, back to REQ ----
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'hBAD0_0000, 1'b1, 30'h2000, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      check("co_empty", 32'(bus.if_valid),  32'd0);
      check("co_req",   32'(bus.imem_req),  32'd1);
      check("co_addr",  32'(bus.imem_addr), 32'h2000);

      // ---- push and pop together at count=1 ----
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'hC000_0000, 1'b0, 30'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'hC000_0001, 1'b0, 30'd0, 1'b1);
      check("pp_head_before", 32'(bus.if_pc), 32'h0C00);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      check("pp_valid", 32'(bus.if_valid), 32'd1);
      check("pp_pc",    32'(bus.if_pc),    32'h0C01);
      check("pp_instr", bus.if_instr,      32'hC000_0001);
      // a redirect now must hide and clear the one remaining entry
      drive(1'b0, 1'b0, 32'd0, 1'b1, 30'h0500, 1'b1);
      check("rd_forced", 32'(bus.if_valid), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("rd_cleared", 32'(bus.if_valid),  32'd0);
      check("rd_addr",    32'(bus.imem_addr), 32'h0500);

      // ---- PC wrap at the top of the word space ----
      drive(1'b0, 1'b0, 32'd0, 1'b1, 30'h3FFF_FFFF, 1'b1);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b1);
      check("wr_addr_top", 32'(bus.imem_addr), 32'h3FFF_FFFF);
      tick();
      drive(1'b0, 1'b1, 32'hE000_000E, 1'b0, 30'd0, 1'b0);
      check("wr_addr_zero", 32'(bus.imem_addr), 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      check("wr_if_pc", 32'(bus.if_pc), 32'h3FFF_FFFF);
      check("wr_instr", bus.if_instr,   32'hE000_000E);

      // ---- reset during WAIT, stale response afterwards is ignored ----
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b1, 32'hF000_0000, 1'b0, 30'd0, 1'b0);
      check("sr_req_after_rst", 32'(bus.imem_req), 32'd1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0);
      check("sr_ignored", 32'(bus.if_valid),  32'd0);
      check("sr_addr",    32'(bus.imem_addr), 32'h0C00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
